// File: rtl/mario_score_pkg.sv
// Shared constants, the VGA side-band bundle and the glyph table for the score strip renderer.
package mario_score_pkg;
   localparam int         CHAR_W     = 8;
   localparam int         CHAR_H     = 16;
   localparam logic [7:0] CODE_BLANK = 8'h0F;
   localparam logic [7:0] CODE_NONE  = 8'hFF;
   localparam logic [7:0] CODE_LAST  = 8'h14;
   localparam int         BLINK_BIT  = 5;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } vga_t;

   // Glyph file contents: every populated cell carries corner marks on rows 0 and 15,
   // and its body rows are 8'h3C ^ code. Code FF is filled solid so the NONE mask matters.
   function automatic logic [7:0] font_row(input logic [7:0] code, input logic [3:0] row);
      logic [7:0] v;
      v = 8'h00;
      if (code == CODE_NONE)
         v = 8'hFF;
      else if (code <= CODE_LAST && code != CODE_BLANK)
         v = (row == 4'd0 || row == 4'd15) ? 8'h81 : (8'h3C ^ code);
      return v;
   endfunction
endpackage

// File: rtl/mario_font_rom.sv
// Synchronous 4096x8 font ROM addressed by {char_code, glyph_row}.
import mario_score_pkg::*;

module mario_font_rom (
   input  logic        clk,
   input  logic [11:0] addr,
   output logic [7:0]  data
);
   always_ff @(posedge clk) begin
      data <= font_row(addr[11:4], addr[3:0]);
   end
endmodule

// File: rtl/mario_score_renderer.sv
// Score strip text overlay on the VGA stream, fixed 3-clock latency.
// Optional blink on alert is enabled with `define MARIO_SCORE_BLINK_EN.
import mario_score_pkg::*;

module mario_score_renderer #(
   parameter int          LEFT       = 16,
   parameter int          TOP        = 8,
   parameter int          COLS       = 69,
   parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic        alert,
   input  logic [7:0]  char_code,
   output logic [7:0]  char_xy,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);
   localparam logic [10:0] X_BEG = 11'(LEFT);
   localparam logic [10:0] X_END = 11'(LEFT + CHAR_W * COLS);
   localparam logic [10:0] Y_BEG = 11'(TOP);
   localparam logic [10:0] Y_END = 11'(TOP + CHAR_H);

   logic        w_in_strip;
   logic [10:0] w_dx;
   logic [3:0]  w_row;
   logic [7:0]  w_font;
   logic        w_bit;
   logic        w_hide;
   logic        w_text;
   logic [11:0] w_rgb;

   vga_t        r_s1, r_s2, r_s3;
   logic [7:0]  r_char_xy;
   logic        r1_in, r2_in, r2_none;
   logic [2:0]  r1_col, r2_col;
   logic [3:0]  r1_row;

   // Offsets are only formed once the range compare passes, so they never wrap.
   always_comb begin
      w_in_strip = (hcount_in >= X_BEG) && (hcount_in < X_END) &&
                   (vcount_in >= Y_BEG) && (vcount_in < Y_END);
      w_dx       = w_in_strip ? (hcount_in - X_BEG) : 11'd0;
      w_row      = w_in_strip ? 4'(vcount_in - Y_BEG) : 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1      <= '0;
         r_char_xy <= '0;
         r1_in     <= 1'b0;
         r1_col    <= '0;
         r1_row    <= '0;
      end else begin
         r_s1   <= vga_t'{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
         r1_in  <= w_in_strip;
         r1_col <= w_dx[2:0];
         r1_row <= w_row;
         if (w_in_strip) r_char_xy <= w_dx[10:3];
      end
   end

   mario_font_rom u_font (
      .clk  (clk),
      .addr ({char_code, r1_row}),
      .data (w_font)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2    <= '0;
         r2_in   <= 1'b0;
         r2_none <= 1'b0;
         r2_col  <= '0;
      end else begin
         r_s2    <= r_s1;
         r2_in   <= r1_in;
         r2_none <= (char_code == CODE_NONE);
         r2_col  <= r1_col;
      end
   end

`ifdef MARIO_SCORE_BLINK_EN
   logic       r_vsync_d;
   logic [5:0] r_frame;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vsync_d <= 1'b0;
         r_frame   <= '0;
      end else begin
         r_vsync_d <= vsync_in;
         if (vsync_in && !r_vsync_d) r_frame <= r_frame + 6'd1;
      end
   end

   assign w_hide = alert & r_frame[BLINK_BIT];
`else
   logic w_unused_alert;
   assign w_unused_alert = alert;
   assign w_hide         = 1'b0;
`endif

   // Bit 7 of the font byte is the leftmost pixel of the cell.
   always_comb begin
      w_bit  = w_font[3'd7 - r2_col];
      w_text = w_bit & r2_in & ~r2_none & ~w_hide;
      w_rgb  = r_s2.rgb;
      if (w_text) w_rgb = TEXT_COLOR;
      if (r_s2.hblnk || r_s2.vblnk) w_rgb = 12'h000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3 <= '0;
      end else begin
         r_s3     <= r_s2;
         r_s3.rgb <= w_rgb;
      end
   end

   assign char_xy    = r_char_xy;
   assign hcount_out = r_s3.hcount;
   assign vcount_out = r_s3.vcount;
   assign hsync_out  = r_s3.hsync;
   assign vsync_out  = r_s3.vsync;
   assign hblnk_out  = r_s3.hblnk;
   assign vblnk_out  = r_s3.vblnk;
   assign rgb_out    = r_s3.rgb;
endmodule
